// File: rtl/alu_rr_arbiter.sv
// Round-robin shared 64-bit ALU (add/sub/and/xor) for two requesters.
// Registered result with valid/ready response; owns condition codes ZF/SF/OF.
module alu_rr_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_set_cc,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_set_cc,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_of,

    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,

    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_XOR = 2'd3;
    localparam int         MSB    = WIDTH - 1;

    logic             last;
    logic             free;
    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic             sel_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_set_cc;
    logic [WIDTH-1:0] alu_r;
    logic             alu_of;

    assign free = !rsp_valid || rsp_ready;

    // A lone requester always wins; on contention the one not served last wins.
    assign gnt0 = req0_valid && (!req1_valid || last);
    assign gnt1 = req1_valid && (!req0_valid || !last);

    // Gated by rst_n so nothing is handed out during a reset cycle.
    assign req0_ready = rst_n && free && gnt0;
    assign req1_ready = rst_n && free && gnt1;
    assign accept     = req0_ready || req1_ready;
    assign sel_id     = req1_ready;

    always_comb begin
        if (sel_id) begin
            sel_op     = req1_op;
            sel_a      = req1_a;
            sel_b      = req1_b;
            sel_set_cc = req1_set_cc;
        end else begin
            sel_op     = req0_op;
            sel_a      = req0_a;
            sel_b      = req0_b;
            sel_set_cc = req0_set_cc;
        end
    end

    always_comb begin
        alu_r  = '0;
        alu_of = 1'b0;
        case (sel_op)
            OP_ADD: begin
                alu_r  = sel_a + sel_b;
                alu_of = (sel_a[MSB] == sel_b[MSB]) && (alu_r[MSB] != sel_a[MSB]);
            end
            OP_SUB: begin
                alu_r  = sel_a - sel_b;
                alu_of = (sel_a[MSB] != sel_b[MSB]) && (alu_r[MSB] != sel_a[MSB]);
            end
            OP_AND: alu_r = sel_a & sel_b;
            OP_XOR: alu_r = sel_a ^ sel_b;
            default: alu_r = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_of     <= 1'b0;
            cc_zf      <= 1'b1;
            cc_sf      <= 1'b0;
            cc_of      <= 1'b0;
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            last       <= 1'b1;
        end else begin
            if (accept) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= sel_id;
                rsp_result <= alu_r;
                rsp_of     <= alu_of;
                last       <= sel_id;
                if (sel_set_cc) begin
                    cc_zf <= (alu_r == '0);
                    cc_sf <= alu_r[MSB];
                    cc_of <= alu_of;
                end
                if (!sel_id && grant_cnt0 != {CNT_W{1'b1}})
                    grant_cnt0 <= grant_cnt0 + CNT_W'(1);
                if (sel_id && grant_cnt1 != {CNT_W{1'b1}})
                    grant_cnt1 <= grant_cnt1 + CNT_W'(1);
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: behavioural model plus result scoreboard,
// with each comparison made as an immediate assertion.
module tb_alu_rr_arbiter;

    localparam int WIDTH = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             req0_set_cc, req1_set_cc;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_of;
    logic [WIDTH-1:0] rsp_result;
    logic             cc_zf, cc_sf, cc_of;
    logic [CNT_W-1:0] grant_cnt0, grant_cnt1;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_set_cc(req0_set_cc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_set_cc(req1_set_cc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_of(rsp_of),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    typedef struct packed {
        logic             id;
        logic             of;
        logic [WIDTH-1:0] r;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    logic             m_valid = 1'b0;
    logic             m_last  = 1'b1;
    logic             m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
    logic [CNT_W-1:0] m_cnt0 = '0, m_cnt1 = '0;
    logic             last_gnt = 1'b0;
    logic             acc_seen = 1'b0;
    logic [CNT_W-1:0] base0, base1;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU: overflow from a sign-extended 65-bit computation.
    function automatic exp_t model_alu(input logic id, input logic [1:0] op,
                                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH:0] s;
        e.id = id;
        e.of = 1'b0;
        e.r  = '0;
        s    = '0;
        case (op)
            2'd0: begin s = {a[WIDTH-1], a} + {b[WIDTH-1], b}; e.r = s[WIDTH-1:0]; e.of = s[WIDTH] ^ s[WIDTH-1]; end
            2'd1: begin s = {a[WIDTH-1], a} - {b[WIDTH-1], b}; e.r = s[WIDTH-1:0]; e.of = s[WIDTH] ^ s[WIDTH-1]; end
            2'd2: e.r = a & b;
            default: e.r = a ^ b;
        endcase
        return e;
    endfunction

    task automatic cycle();
        logic free, g0, g1, e0, e1, id, scc;
        exp_t e;
        @(negedge clk);
        free = !m_valid || rsp_ready;
        g0 = req0_valid && (!req1_valid || m_last);
        g1 = req1_valid && (!req0_valid || !m_last);
        e0 = rst_n && free && g0;
        e1 = rst_n && free && g1;
        chk("req0_ready", WIDTH'(req0_ready), WIDTH'(e0));
        chk("req1_ready", WIDTH'(req1_ready), WIDTH'(e1));
        if (m_valid && q.size() > 0) begin
            chk("rsp_id", WIDTH'(rsp_id), WIDTH'(q[0].id));
            chk("rsp_result", rsp_result, q[0].r);
            chk("rsp_of", WIDTH'(rsp_of), WIDTH'(q[0].of));
        end
        acc_seen = 1'b0;
        if (!rst_n) begin
            q.delete();
            m_valid = 1'b0; m_last = 1'b1;
            m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
            m_cnt0 = '0; m_cnt1 = '0;
        end else begin
            if (m_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
            if (e0 || e1) begin
                id  = e1;
                scc = id ? req1_set_cc : req0_set_cc;
                e   = id ? model_alu(1'b1, req1_op, req1_a, req1_b)
                         : model_alu(1'b0, req0_op, req0_a, req0_b);
                q.push_back(e);
                m_valid = 1'b1;
                m_last  = id;
                last_gnt = id;
                acc_seen = 1'b1;
                if (scc) begin
                    m_zf = (e.r == '0); m_sf = e.r[WIDTH-1]; m_of = e.of;
                end
                if (!id && m_cnt0 != {CNT_W{1'b1}}) m_cnt0 = m_cnt0 + CNT_W'(1);
                if (id && m_cnt1 != {CNT_W{1'b1}}) m_cnt1 = m_cnt1 + CNT_W'(1);
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", WIDTH'(rsp_valid), WIDTH'(m_valid));
        chk("cc_zf", WIDTH'(cc_zf), WIDTH'(m_zf));
        chk("cc_sf", WIDTH'(cc_sf), WIDTH'(m_sf));
        chk("cc_of", WIDTH'(cc_of), WIDTH'(m_of));
        chk("grant_cnt0", WIDTH'(grant_cnt0), WIDTH'(m_cnt0));
        chk("grant_cnt1", WIDTH'(grant_cnt1), WIDTH'(m_cnt1));
    endtask

    task automatic drive0(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic scc);
        req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_set_cc = scc;
    endtask

    task automatic drive1(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic scc);
        req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_set_cc = scc;
    endtask

    task automatic chk_cc(input string tag, input logic zf, input logic sf, input logic of);
        chk({tag, "_zf"}, WIDTH'(cc_zf), WIDTH'(zf));
        chk({tag, "_sf"}, WIDTH'(cc_sf), WIDTH'(sf));
        chk({tag, "_of"}, WIDTH'(cc_of), WIDTH'(of));
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        drive1(1'b0, 2'd0, '0, '0, 1'b0);
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("reset_rsp_valid", WIDTH'(rsp_valid), '0);
        chk("reset_rsp_id", WIDTH'(rsp_id), '0);
        chk("reset_rsp_result", rsp_result, '0);
        chk("reset_rsp_of", WIDTH'(rsp_of), '0);
        chk_cc("reset_cc", 1'b1, 1'b0, 1'b0);

        // sub overflow: max positive minus min negative
        drive0(1'b1, 2'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1);
        cycle();
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        chk("t1_valid", WIDTH'(rsp_valid), 64'd1);
        chk("t1_id", WIDTH'(rsp_id), 64'd0);
        chk("t1_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_of", WIDTH'(rsp_of), 64'd1);
        chk_cc("t1_cc", 1'b0, 1'b1, 1'b1);

        drive0(1'b1, 2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
        cycle();
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        chk("t2_result", rsp_result, 64'd0);
        chk("t2_of", WIDTH'(rsp_of), 64'd0);
        chk_cc("t2_cc", 1'b1, 1'b0, 1'b0);
        drive1(1'b1, 2'd0, 64'd5, 64'hE, 1'b0);
        cycle();
        drive1(1'b0, 2'd0, '0, '0, 1'b0);
        chk("t2b_id", WIDTH'(rsp_id), 64'd1);
        chk("t2b_result", rsp_result, 64'h13);
        chk_cc("t2b_cc", 1'b1, 1'b0, 1'b0);

        // Contention with the consumer always ready
        base0 = m_cnt0;
        base1 = m_cnt1;
        drive0(1'b1, 2'd0, 64'd100, 64'd1, 1'b0);
        drive1(1'b1, 2'd3, 64'h55, 64'h0F, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("t3_accept", WIDTH'(acc_seen), 64'd1);
            chk("t3_order", WIDTH'(last_gnt), WIDTH'(i % 2));
            chk("t3_valid", WIDTH'(rsp_valid), 64'd1);
            if (last_gnt) req1_a = req1_a + 64'd7;
            else req0_a = req0_a + 64'd3;
        end
        chk("t3_cnt0", WIDTH'(grant_cnt0 - base0), 64'd3);
        chk("t3_cnt1", WIDTH'(grant_cnt1 - base1), 64'd3);
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        drive1(1'b0, 2'd0, '0, '0, 1'b0);
        cycle();

        // Stalled response holds and blocks the other requester
        rsp_ready = 1'b0;
        drive0(1'b1, 2'd0, 64'd1, 64'd2, 1'b0);
        cycle();
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        drive1(1'b1, 2'd1, 64'd10, 64'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t4_hold_result", rsp_result, 64'd3);
            chk("t4_hold_id", WIDTH'(rsp_id), 64'd0);
            chk("t4_no_accept", WIDTH'(acc_seen), 64'd0);
        end
        rsp_ready = 1'b1;
        cycle();
        drive1(1'b0, 2'd0, '0, '0, 1'b0);
        chk("t4_accept", WIDTH'(acc_seen), 64'd1);
        chk("t4_id", WIDTH'(rsp_id), 64'd1);
        chk("t4_result", rsp_result, 64'd7);

        // Arithmetic corners
        drive0(1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        cycle();
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        chk("t5_add_result", rsp_result, 64'h8000_0000_0000_0000);
        chk("t5_add_of", WIDTH'(rsp_of), 64'd1);
        chk_cc("t5_add_cc", 1'b0, 1'b1, 1'b1);
        drive1(1'b1, 2'd2, 64'hF0, 64'h3C, 1'b1);
        cycle();
        drive1(1'b0, 2'd0, '0, '0, 1'b0);
        chk("t5_and_result", rsp_result, 64'h30);
        chk("t5_and_of", WIDTH'(rsp_of), 64'd0);
        chk_cc("t5_and_cc", 1'b0, 1'b0, 1'b0);
        drive0(1'b1, 2'd3, 64'hFF, 64'hFF, 1'b1);
        cycle();
        chk("t5_xor_result", rsp_result, 64'd0);
        chk_cc("t5_xor_cc", 1'b1, 1'b0, 1'b0);

        // Reset with a held result and both requesters pending
        drive0(1'b1, 2'd0, 64'd11, 64'd22, 1'b1);
        drive1(1'b1, 2'd0, 64'd33, 64'd44, 1'b1);
        rsp_ready = 1'b0;
        rst_n = 1'b0;
        cycle();
        chk("t6_no_accept", WIDTH'(acc_seen), 64'd0);
        chk("t6_valid", WIDTH'(rsp_valid), 64'd0);
        chk_cc("t6_cc", 1'b1, 1'b0, 1'b0);
        chk("t6_cnt0", WIDTH'(grant_cnt0), 64'd0);
        chk("t6_cnt1", WIDTH'(grant_cnt1), 64'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        cycle();
        chk("t6_first_grant", WIDTH'(last_gnt), 64'd0);
        chk("t6_rsp_id", WIDTH'(rsp_id), 64'd0);
        chk("t6_result", rsp_result, 64'd33);
        drive0(1'b0, 2'd0, '0, '0, 1'b0);
        drive1(1'b0, 2'd0, '0, '0, 1'b0);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
